// File: rtl/mont_conv_pkg.sv
// Shared definitions for the Montgomery domain converter: mode codes, FSM states, defaults.
// Optional build macro MONT_CONV_DUAL_STEP_EN (see mont_conv.sv).
package mont_conv_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned CHAR      = 251;

  localparam logic MODE_TO_MONT   = 1'b0;
  localparam logic MODE_FROM_MONT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mont_conv_step.sv
// One combinational radix-2 step: modular doubling (to-Montgomery) or modular halving (from-Montgomery).
module mont_conv_step
  import mont_conv_pkg::*;
#(
  parameter int unsigned W = WORD_SIZE,
  parameter int unsigned P = CHAR
) (
  input  logic [W:0] acc_i,
  input  logic       mode_i,
  output logic [W:0] acc_o
);

  localparam int unsigned AW = W + 1;
  localparam logic [W:0]  P_A = AW'(P);

  logic [W:0] t;

  // acc_i < P < 2^W, so both 2*acc and acc+P fit in W+1 bits
  always_comb begin
    t     = '0;
    acc_o = acc_i;
    if (mode_i == MODE_TO_MONT) begin
      t     = {acc_i[W-1:0], 1'b0};
      acc_o = (t >= P_A) ? (t - P_A) : t;
    end else begin
      t     = acc_i + (acc_i[0] ? P_A : AW'(0));
      acc_o = t >> 1;
    end
  end

endmodule

// File: rtl/mont_conv.sv
// Iterative Montgomery domain converter (Z = X*R mod P or X*R^-1 mod P, R = 2^W) with valid/ready I/O.
// Define MONT_CONV_DUAL_STEP_EN to chain two radix-2 steps per RUN cycle (W must be even).
module mont_conv
  import mont_conv_pkg::*;
#(
  parameter int unsigned W = WORD_SIZE,
  parameter int unsigned P = CHAR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] X,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Z
);

`ifdef MONT_CONV_DUAL_STEP_EN
  localparam int unsigned STEPS = W / 2;
`else
  localparam int unsigned STEPS = W;
`endif
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
  localparam logic [W-1:0]     P_W  = W'(P);

  state_e           state_q, state_d;
  logic [W:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     z_q, z_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W:0]       acc_step;

`ifdef MONT_CONV_DUAL_STEP_EN
  if ((W % 2) != 0) begin : g_odd_w
    $error("mont_conv: MONT_CONV_DUAL_STEP_EN requires even W");
  end

  logic [W:0] acc_mid;

  mont_conv_step #(.W(W), .P(P)) u_step_a (.acc_i(acc_q),   .mode_i(mode_q), .acc_o(acc_mid));
  mont_conv_step #(.W(W), .P(P)) u_step_b (.acc_i(acc_mid), .mode_i(mode_q), .acc_o(acc_step));
`else
  mont_conv_step #(.W(W), .P(P)) u_step_a (.acc_i(acc_q), .mode_i(mode_q), .acc_o(acc_step));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_TO_MONT;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    z_d         = z_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Single conditional subtract suffices since X < 2^W < 2P
          acc_d      = (X >= P_W) ? {1'b0, X - P_W} : {1'b0, X};
          mode_d     = mode;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          z_d         = acc_step[W-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_mont_conv.sv
// Self-checking bench for mont_conv (W=8, P=251): directed cases plus randomized stream vs. arithmetic model.
module tb_mont_conv;

  localparam int unsigned W = 8;
  localparam int unsigned P = 251;
`ifdef MONT_CONV_DUAL_STEP_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif
  localparam int N_RAND = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] X;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Z;

  int checks = 0;
  int failures = 0;

  mont_conv #(.W(W), .P(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .X        (X),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic with R = 2^W
  function automatic longint ref_conv(input bit m, input longint x);
    longint xr, r, rinv;
    xr   = x % P;
    r    = (longint'(1) << W) % P;
    rinv = 0;
    for (longint k = 1; k < P; k++)
      if ((k * r) % P == 1) rinv = k;
    return m ? (xr * rinv) % P : (xr * r) % P;
  endfunction

  // Offer one operand, wait for the result; out_ready is left as the caller set it
  task automatic do_op(input bit m, input logic [W-1:0] x, output logic [W-1:0] z, output int lat);
    int guard;
    mode = m; X = x; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = W'($urandom);
    mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    z = Z;
  endtask

  task automatic directed(input string tag, input bit m, input logic [W-1:0] x, input longint exp);
    logic [W-1:0] z;
    int lat;
    out_ready = 1'b1;
    do_op(m, x, z, lat);
    check_eq({tag, "_z"}, z, exp);
    check_eq({tag, "_lat"}, lat, LAT);
    @(posedge clk); #1;
    check_eq({tag, "_ov_drop"}, out_valid, 0);
    check_eq({tag, "_rdy_back"}, in_ready, 1);
  endtask

  longint exp_q[$];
  int     got;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] z;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; X = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_rdy", in_ready, 1);
    check_eq("rst_z", Z, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("to_1",      1'b0, 8'd1,   5);
    directed("to_250",    1'b0, 8'd250, 246);
    directed("from_246",  1'b1, 8'd246, 250);
    directed("from_5",    1'b1, 8'd5,   1);
    directed("from_0",    1'b1, 8'd0,   0);
    directed("to_0",      1'b0, 8'd0,   0);
    directed("to_253",    1'b0, 8'd253, 10);

    // Stall in DONE with a competing operand offered
    out_ready = 1'b0;
    do_op(1'b0, 8'd1, z, lat);
    check_eq("hold_z0", z, 5);
    mode = 1'b0; X = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("hold_z", Z, 5);
      check_eq("hold_rdy", in_ready, 0);
      check_eq("hold_ov", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_ov", out_valid, 0);
    check_eq("rel_rdy", in_ready, 1);
    @(posedge clk); #1;
    check_eq("rel_no_accept", in_ready, 1);

    // Reset during RUN
    mode = 1'b0; X = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_ov", out_valid, 0);
    check_eq("mid_rst_z", Z, 0);
    check_eq("mid_rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    directed("post_rst", 1'b1, 8'd10, ref_conv(1'b1, 10));

    // Randomized back-to-back stream with random output stalls
    got = 0;
    fork
      begin : producer
        for (int i = 0; i < N_RAND; i++) begin
          bit m;
          logic [W-1:0] x;
          int guard;
          m = 1'($urandom);
          x = W'($urandom_range(0, P - 1));
          mode = m; X = x; in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 1000) begin @(posedge clk); #1; guard++; end
          exp_q.push_back(ref_conv(m, longint'(x)));
          @(posedge clk); #1;
          in_valid = 1'b0;
          X = W'($urandom);
          mode = 1'($urandom);
          if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
      end
      begin : consumer
        int budget;
        budget = 0;
        while (got < N_RAND && budget < 5000) begin
          @(posedge clk); #1;
          budget++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("rand_extra", 1, 0);
            else check_eq("rand_z", Z, exp_q.pop_front());
            got++;
          end
        end
      end
    join
    check_eq("rand_count", got, N_RAND);
    check_eq("rand_left", exp_q.size(), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rand_idle_ov", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
